slot_reel_engine: RTL and testbench
===================================

// Module: slot_reel_engine
// PURPOSE
//  Parametrised slot-machine core: N reels, configurable symbol count, on-chip tick
//  generation, start/stop control FSM, win (fever) detection, multiplexed 7-seg drive.
//  Sits directly under the board top; the top only inverts the board switches and
//  wires the LED/segment pins.
//  Generalises the fixed 3-reel 6 MHz design: reel count, symbol count and clock rates
//  are parameters, and it adds a timed fever light show plus a busy flag.
// PARAMETERS
//  CLK_HZ        6000000  mainClock frequency
//  SPIN_HZ       10       reel advance rate (spin_tick)
//  SCAN_HZ       1000     digit-scan rate (scan_tick)
//  REELS         3        number of reels / digits, 1..8
//  SYMBOLS       10       symbols per reel, 2..16; reel value 0..SYMBOLS-1
//  FEVER_TICKS   20       fever-show duration in spin_ticks, >=1
//  LEDS          16       width of fever LED bar, >=2
// PORTS
//  mainClock  in   1      system clock
//  reset      in   1      asynchronous, active-low reset
//  start      in   1      start request, active-high level (asynchronous to mainClock)
//  stop       in   REELS  per-reel stop request, active-high level; bit i = reel i
//  segsel     out  REELS  one-hot digit select, active-high
//  seg        out  8      segments {dp,g,f,e,d,c,b,a}, active-high
//  extled     out  LEDS   fever light bar
//  fever      out  1      high while in FEVER
//  busy       out  1      high in SPIN or FEVER
// BEHAVIOUR
//  - Reset (reset=0, async assert, sync release): state=IDLE; all reels=0; all reels
//    marked stopped; scan index=0; dividers=0.
//    Outputs in reset: segsel=1 (reel 0), seg shows reel 0 decode of value 0,
//    extled=0, fever=0, busy=0.
//  - Ticks: spin_tick is a 1-cycle pulse every CLK_HZ/SPIN_HZ cycles.
//    scan_tick is a 1-cycle pulse every CLK_HZ/SCAN_HZ cycles.
//    Both use integer division; the first pulse comes N cycles after reset release.
//  - Inputs: start and stop each pass through a 2-flop synchroniser, then a rising-edge
//    detector. Only the 0->1 edges act; held levels do nothing more.
//    Latency from pin to action is 3 cycles.
//  - FSM IDLE: start edge -> SPIN; all reels are marked running in the same cycle.
//    Stop edges are ignored.
//  - FSM SPIN: on spin_tick each running reel does value+1, wrapping SYMBOLS-1 -> 0.
//    A stop edge on a running reel freezes it at its current value.
//    Stop edge and spin_tick in the same cycle: the stop wins and that reel does not
//    advance. Stop on an already-stopped reel is ignored. Start edges are ignored.
//  - SPIN exit: the cycle after the last reel stops, compare all reels.
//    All equal -> FEVER; otherwise -> IDLE.
//    When several stops land in one cycle they are all applied, then the evaluation
//    proceeds as above.
//  - FSM FEVER: on entry extled=1 (LSB lit) and tick count=0.
//    On each spin_tick extled rotates left by one (MSB wraps to LSB) and the count
//    increments. Once FEVER_TICKS spin_ticks have passed -> IDLE and extled=0.
//    Start and stop are ignored during FEVER.
//  - busy=(state!=IDLE); fever=(state==FEVER). Both are registered.
//  - Display: on scan_tick the scan index increments, wrapping REELS-1 -> 0.
//    segsel=1<<index. seg=hex decode of reel[index] (0-9, A-F), dp=0.
//    The display runs in every state; segsel and seg change in the same cycle.
//  - Reset asserted mid-SPIN or mid-FEVER takes effect immediately, with all values as
//    listed above.
// TESTING (bench params: CLK_HZ=1000, SPIN_HZ=100, SCAN_HZ=500, REELS=3, SYMBOLS=10,
//          FEVER_TICKS=4, LEDS=8 -> spin_tick every 10 cycles, scan_tick every 2)
//  1 Reset: hold reset=0 with random inputs -> segsel=3'b001, seg=0x3F, extled=0,
//    busy=0, fever=0.
//  2 Spin/wrap: start pulse, then 12 spin_ticks with no stop -> every reel reads 2
//    (9->0 wrap seen); busy=1.
//  3 Stop/tick collision: stop[1] edge in the same cycle as a spin_tick -> reel1 holds
//    its pre-tick value; reels 0 and 2 advance.
//  4 Loss: stop the reels at values 3,3,5 -> next cycle state=IDLE, busy=0, fever=0,
//    extled=0.
//  5 Win: force stops at 7,7,7 -> fever=1, extled=8'h01, then 02,04,08 on successive
//    spin_ticks; after 4 ticks: fever=0, extled=0. A start edge during FEVER has no
//    effect.
//  6 Scan and async reset: segsel steps 001->010->100->001 every 2 cycles, each digit
//    decode matching its reel. Asserting reset mid-SPIN returns every output to the
//    test-1 values at once, with no clock edge needed.

Source files
------------

// File: rtl/slot_reel_engine.sv
// Slot-machine core: N reels with start/stop control, win (fever) detection,
// a timed fever light show and a multiplexed 7-segment display.
module slot_reel_engine #(
  parameter int CLK_HZ      = 6000000,
  parameter int SPIN_HZ     = 10,
  parameter int SCAN_HZ     = 1000,
  parameter int REELS       = 3,
  parameter int SYMBOLS     = 10,
  parameter int FEVER_TICKS = 20,
  parameter int LEDS        = 16
) (
  input  logic              mainClock,
  input  logic              reset,
  input  logic              start,
  input  logic [REELS-1:0]  stop,
  output logic [REELS-1:0]  segsel,
  output logic [7:0]        seg,
  output logic [LEDS-1:0]   extled,
  output logic              fever,
  output logic              busy
);

  localparam int SPIN_DIV = (CLK_HZ / SPIN_HZ > 1) ? CLK_HZ / SPIN_HZ : 1;
  localparam int SCAN_DIV = (CLK_HZ / SCAN_HZ > 1) ? CLK_HZ / SCAN_HZ : 1;
  localparam int SPW      = $clog2(SPIN_DIV + 1);
  localparam int SCW      = $clog2(SCAN_DIV + 1);
  localparam int VW       = $clog2(SYMBOLS);
  localparam int IW       = (REELS > 1) ? $clog2(REELS) : 1;
  localparam int FW       = $clog2(FEVER_TICKS + 1);

  typedef enum logic [1:0] {IDLE, SPIN, FEVER} state_t;

  state_t            state_reg;
  logic [VW-1:0]     reels_reg [REELS];
  logic [VW-1:0]     reel_inc  [REELS];
  logic [REELS-1:0]  reel_match;
  logic [REELS-1:0]  running_reg;
  logic [FW-1:0]     fever_cnt_reg;
  logic [LEDS-1:0]   extled_reg;
  logic              busy_reg;
  logic              fever_reg;
  logic              all_equal;

  logic [SPW-1:0]    spin_cnt_reg;
  logic [SCW-1:0]    scan_cnt_reg;
  logic              spin_tick;
  logic              scan_tick;
  logic [IW-1:0]     scan_idx_reg;
  logic [3:0]        digit;

  logic              start_meta_reg, start_sync_reg, start_prev_reg;
  logic [REELS-1:0]  stop_meta_reg, stop_sync_reg, stop_prev_reg;
  logic              start_rise;
  logic [REELS-1:0]  stop_rise;

  // Two-flop synchronisers followed by a one-cycle rising-edge detector.
  always_ff @(posedge mainClock or negedge reset) begin
    if (!reset) begin
      start_meta_reg <= 1'b0;
      start_sync_reg <= 1'b0;
      start_prev_reg <= 1'b0;
      stop_meta_reg  <= '0;
      stop_sync_reg  <= '0;
      stop_prev_reg  <= '0;
    end else begin
      start_meta_reg <= start;
      start_sync_reg <= start_meta_reg;
      start_prev_reg <= start_sync_reg;
      stop_meta_reg  <= stop;
      stop_sync_reg  <= stop_meta_reg;
      stop_prev_reg  <= stop_sync_reg;
    end
  end

  assign start_rise = start_sync_reg & ~start_prev_reg;
  assign stop_rise  = stop_sync_reg & ~stop_prev_reg;

  always_ff @(posedge mainClock or negedge reset) begin
    if (!reset) begin
      spin_cnt_reg <= '0;
      scan_cnt_reg <= '0;
    end else begin
      spin_cnt_reg <= spin_tick ? '0 : spin_cnt_reg + SPW'(1);
      scan_cnt_reg <= scan_tick ? '0 : scan_cnt_reg + SCW'(1);
    end
  end

  assign spin_tick = (spin_cnt_reg == SPW'(SPIN_DIV - 1));
  assign scan_tick = (scan_cnt_reg == SCW'(SCAN_DIV - 1));

  genvar gi;
  generate
    for (gi = 0; gi < REELS; gi++) begin : g_reel
      assign reel_inc[gi]   = (reels_reg[gi] == VW'(SYMBOLS - 1)) ? '0 : reels_reg[gi] + VW'(1);
      assign reel_match[gi] = (reels_reg[gi] == reels_reg[0]);
    end
  endgenerate

  assign all_equal = &reel_match;

  always_ff @(posedge mainClock or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      running_reg   <= '0;
      fever_cnt_reg <= '0;
      extled_reg    <= '0;
      busy_reg      <= 1'b0;
      fever_reg     <= 1'b0;
      for (int i = 0; i < REELS; i++) reels_reg[i] <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_rise) begin
            state_reg   <= SPIN;
            running_reg <= '1;
            busy_reg    <= 1'b1;
          end
        end
        SPIN: begin
          if (running_reg == '0) begin
            if (all_equal) begin
              state_reg     <= FEVER;
              fever_reg     <= 1'b1;
              extled_reg    <= LEDS'(1);
              fever_cnt_reg <= '0;
            end else begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end
          end else begin
            // A stop landing on a tick freezes the reel before it can advance.
            for (int i = 0; i < REELS; i++) begin
              if (running_reg[i]) begin
                if (stop_rise[i])   running_reg[i] <= 1'b0;
                else if (spin_tick) reels_reg[i]   <= reel_inc[i];
              end
            end
          end
        end
        FEVER: begin
          if (spin_tick) begin
            if (fever_cnt_reg == FW'(FEVER_TICKS - 1)) begin
              state_reg  <= IDLE;
              extled_reg <= '0;
              busy_reg   <= 1'b0;
              fever_reg  <= 1'b0;
            end else begin
              extled_reg    <= {extled_reg[LEDS-2:0], extled_reg[LEDS-1]};
              fever_cnt_reg <= fever_cnt_reg + FW'(1);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign extled = extled_reg;
  assign busy   = busy_reg;
  assign fever  = fever_reg;

  always_ff @(posedge mainClock or negedge reset) begin
    if (!reset) begin
      scan_idx_reg <= '0;
    end else if (scan_tick) begin
      scan_idx_reg <= (scan_idx_reg == IW'(REELS - 1)) ? '0 : scan_idx_reg + IW'(1);
    end
  end

  // Select and segment pattern both derive from the scan index, so they switch together.
  assign segsel = REELS'(1) << scan_idx_reg;
  assign digit  = 4'(reels_reg[scan_idx_reg]);

  always_comb begin
    seg = 8'h00;
    case (digit)
      4'h0: seg = 8'h3F;
      4'h1: seg = 8'h06;
      4'h2: seg = 8'h5B;
      4'h3: seg = 8'h4F;
      4'h4: seg = 8'h66;
      4'h5: seg = 8'h6D;
      4'h6: seg = 8'h7D;
      4'h7: seg = 8'h07;
      4'h8: seg = 8'h7F;
      4'h9: seg = 8'h6F;
      4'hA: seg = 8'h77;
      4'hB: seg = 8'h7C;
      4'hC: seg = 8'h39;
      4'hD: seg = 8'h5E;
      4'hE: seg = 8'h79;
      4'hF: seg = 8'h71;
      default: seg = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_slot_reel_engine.sv
// Self-checking bench for slot_reel_engine: randomized rounds checked against a
// timeline model of reel values, game phases and display scanning.
module tb_slot_reel_engine;
  localparam int SYM  = 10;
  localparam int TICK = 10;
  localparam int FT   = 4;
  localparam int BIG  = 1 << 30;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [2:0] stop = 3'b000;
  logic [2:0] segsel;
  logic [7:0] seg;
  logic [7:0] extled;
  logic       fever;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;
  int run_act = -1;
  int base[3];
  int stop_at[3];
  int sd[3];
  int st_at  = -100;
  int st2_at = -100;

  slot_reel_engine #(
    .CLK_HZ(1000), .SPIN_HZ(100), .SCAN_HZ(500), .REELS(3),
    .SYMBOLS(10), .FEVER_TICKS(4), .LEDS(8)
  ) dut (
    .mainClock(clk), .reset(reset), .start(start), .stop(stop),
    .segsel(segsel), .seg(seg), .extled(extled), .fever(fever), .busy(busy)
  );

  always #5 clk = ~clk;

  // Edge count since reset release; ticks act on edges that are multiples of TICK.
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] hex7(int v);
    case (v)
      0: return 8'h3F;  1: return 8'h06;  2: return 8'h5B;  3: return 8'h4F;
      4: return 8'h66;  5: return 8'h6D;  6: return 8'h7D;  7: return 8'h07;
      8: return 8'h7F;  9: return 8'h6F;  10: return 8'h77; 11: return 8'h7C;
      12: return 8'h39; 13: return 8'h5E; 14: return 8'h79; default: return 8'h71;
    endcase
  endfunction

  function automatic int ticks(int a, int b);
    return (b > a) ? (b / TICK - a / TICK) : 0;
  endfunction

  function automatic int exp_reel(int i, int now);
    int e;
    if (run_act < 0 || now < run_act) return base[i];
    e = (stop_at[i] >= 0 && stop_at[i] <= now) ? stop_at[i] - 1 : now;
    return (base[i] + ticks(run_act, e)) % SYM;
  endfunction

  function automatic int last_stop();
    int m = 0;
    for (int i = 0; i < 3; i++) begin
      if (stop_at[i] < 0) return BIG;
      if (stop_at[i] > m) m = stop_at[i];
    end
    return m;
  endfunction

  function automatic bit won();
    return exp_reel(0, BIG) == exp_reel(1, BIG) && exp_reel(1, BIG) == exp_reel(2, BIG);
  endfunction

  function automatic int fever_end();
    int f = last_stop() + 1;
    return (f / TICK + 1) * TICK + (FT - 1) * TICK;
  endfunction

  function automatic logic exp_busy(int now);
    if (run_act < 0 || now < run_act) return 1'b0;
    if (now <= last_stop()) return 1'b1;
    if (!won()) return 1'b0;
    return now < fever_end();
  endfunction

  function automatic logic exp_fever(int now);
    if (run_act < 0 || now <= last_stop() || !won()) return 1'b0;
    return now < fever_end();
  endfunction

  function automatic logic [7:0] exp_led(int now);
    if (!exp_fever(now)) return 8'h00;
    return 8'(1 << ticks(last_stop() + 1, now));
  endfunction

  function automatic logic [2:0] exp_segsel(int now);
    return 3'(1 << ((now / 2) % 3));
  endfunction

  function automatic logic [7:0] exp_seg(int now);
    return hex7(exp_reel((now / 2) % 3, now));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    start = (cyc >= st_at && cyc < st_at + 2) || (cyc >= st2_at && cyc < st2_at + 2);
    for (int i = 0; i < 3; i++) stop[i] = (cyc >= sd[i] && cyc < sd[i] + 2);
  endtask

  task automatic clear_model();
    run_act = -1;
    st_at   = -100;
    st2_at  = -100;
    for (int i = 0; i < 3; i++) begin base[i] = 0; stop_at[i] = -1; sd[i] = -100; end
  endtask

  task automatic release_reset();
    start = 1'b0;
    stop  = 3'b000;
    clear_model();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic new_run(int delay);
    for (int i = 0; i < 3; i++) begin
      base[i] = exp_reel(i, BIG);
      stop_at[i] = -1;
      sd[i] = -100;
    end
    st_at   = cyc + delay;
    st2_at  = -100;
    run_act = st_at + 3;
  endtask

  // Schedule a stop that freezes reel i on value tgt; off (0..9) picks the edge in its window.
  task automatic plan_stop(int i, int tgt, int off);
    int n = (((tgt - base[i]) % SYM) + SYM) % SYM;
    if (n == 0) n = SYM;
    stop_at[i] = (run_act / TICK + n) * TICK + 1 + off;
    sd[i]      = stop_at[i] - 3;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      start = 1'($urandom);
      stop  = 3'($urandom);
      #2;
      n_tests += 5;
      if (segsel !== 3'b001) begin n_fail++; $display("FAIL reset_segsel got %b exp 001", segsel); end
      if (seg !== 8'h3F)     begin n_fail++; $display("FAIL reset_seg got %h exp 3f", seg); end
      if (extled !== 8'h00)  begin n_fail++; $display("FAIL reset_extled got %h exp 00", extled); end
      if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
      if (fever !== 1'b0)    begin n_fail++; $display("FAIL reset_fever got %b exp 0", fever); end
    end
    release_reset();
  endtask

  task automatic test_spin_wrap();
    int t12;
    new_run(1 + int'($urandom % 4));
    t12 = (run_act / TICK + 12) * TICK;
    while (cyc < t12) step();
    for (int k = 0; k < 6; k++) begin
      n_tests += 3;
      if (seg !== 8'h5B) begin n_fail++; $display("FAIL wrap_seg cyc=%0d got %h exp 5b", cyc, seg); end
      if (segsel !== exp_segsel(cyc)) begin n_fail++; $display("FAIL wrap_segsel got %b exp %b", segsel, exp_segsel(cyc)); end
      if (busy !== 1'b1) begin n_fail++; $display("FAIL wrap_busy got %b exp 1", busy); end
      step();
    end
  endtask

  task automatic test_collision();
    int t, s, pre0, pre1, idx, done;
    t = ((cyc + 3) / TICK + 1 + int'($urandom % 2)) * TICK;
    pre0 = exp_reel(0, t - 1);
    pre1 = exp_reel(1, t - 1);
    sd[1] = t - 3;
    stop_at[1] = t;
    while (cyc < t) step();
    for (int k = 0; k < 6; k++) begin
      idx = (cyc / 2) % 3;
      n_tests++;
      if (seg !== exp_seg(cyc)) begin n_fail++; $display("FAIL coll_seg cyc=%0d got %h exp %h", cyc, seg, exp_seg(cyc)); end
      if (idx == 1) begin
        n_tests++;
        if (seg !== hex7(pre1)) begin n_fail++; $display("FAIL coll_hold got %h exp %h", seg, hex7(pre1)); end
      end else if (idx == 0) begin
        n_tests++;
        if (seg !== hex7((pre0 + 1) % SYM)) begin n_fail++; $display("FAIL coll_adv got %h exp %h", seg, hex7((pre0 + 1) % SYM)); end
      end
      step();
    end
    // Reels 0 and 2 stop on the same edge.
    s = cyc + 5 + int'($urandom % 15);
    sd[0] = s - 3; sd[2] = s - 3;
    stop_at[0] = s; stop_at[2] = s;
    done = won() ? fever_end() + 3 : s + 4;
    while (cyc < done) begin
      n_tests += 4;
      if (busy !== exp_busy(cyc))    begin n_fail++; $display("FAIL coll_busy cyc=%0d got %b exp %b", cyc, busy, exp_busy(cyc)); end
      if (fever !== exp_fever(cyc))  begin n_fail++; $display("FAIL coll_fever cyc=%0d got %b exp %b", cyc, fever, exp_fever(cyc)); end
      if (extled !== exp_led(cyc))   begin n_fail++; $display("FAIL coll_extled cyc=%0d got %h exp %h", cyc, extled, exp_led(cyc)); end
      if (seg !== exp_seg(cyc))      begin n_fail++; $display("FAIL coll_seg2 cyc=%0d got %h exp %h", cyc, seg, exp_seg(cyc)); end
      step();
    end
  endtask

  task automatic test_loss();
    int l;
    new_run(1 + int'($urandom % 3));
    plan_stop(0, 3, int'($urandom % 10));
    plan_stop(1, 3, int'($urandom % 10));
    plan_stop(2, 5, int'($urandom % 10));
    l = last_stop();
    while (cyc <= l + 3) begin
      n_tests += 4;
      if (busy !== exp_busy(cyc))   begin n_fail++; $display("FAIL loss_busy cyc=%0d got %b exp %b", cyc, busy, exp_busy(cyc)); end
      if (fever !== exp_fever(cyc)) begin n_fail++; $display("FAIL loss_fever cyc=%0d got %b exp %b", cyc, fever, exp_fever(cyc)); end
      if (extled !== exp_led(cyc))  begin n_fail++; $display("FAIL loss_extled cyc=%0d got %h exp %h", cyc, extled, exp_led(cyc)); end
      if (seg !== exp_seg(cyc))     begin n_fail++; $display("FAIL loss_seg cyc=%0d got %h exp %h", cyc, seg, exp_seg(cyc)); end
      if (cyc == l + 1) begin
        n_tests++;
        if ({busy, fever, extled} !== 10'b0) begin n_fail++; $display("FAIL loss_idle got busy=%b fever=%b extled=%h exp 0 0 00", busy, fever, extled); end
      end
      step();
    end
  endtask

  task automatic test_win();
    int f, e;
    new_run(1 + int'($urandom % 3));
    for (int i = 0; i < 3; i++) plan_stop(i, 7, int'($urandom % 10));
    f = last_stop() + 1;
    e = fever_end();
    st2_at = f + 2;
    while (cyc < e + 4) begin
      n_tests += 4;
      if (busy !== exp_busy(cyc))   begin n_fail++; $display("FAIL win_busy cyc=%0d got %b exp %b", cyc, busy, exp_busy(cyc)); end
      if (fever !== exp_fever(cyc)) begin n_fail++; $display("FAIL win_fever cyc=%0d got %b exp %b", cyc, fever, exp_fever(cyc)); end
      if (extled !== exp_led(cyc))  begin n_fail++; $display("FAIL win_extled cyc=%0d got %h exp %h", cyc, extled, exp_led(cyc)); end
      if (seg !== exp_seg(cyc))     begin n_fail++; $display("FAIL win_seg cyc=%0d got %h exp %h", cyc, seg, exp_seg(cyc)); end
      if (cyc == f) begin
        n_tests++;
        if ({fever, extled} !== 9'h101) begin n_fail++; $display("FAIL win_entry got fever=%b extled=%h exp 1 01", fever, extled); end
      end
      if (cyc == e) begin
        n_tests++;
        if ({busy, fever, extled} !== 10'b0) begin n_fail++; $display("FAIL win_exit got busy=%b fever=%b extled=%h exp 0 0 00", busy, fever, extled); end
      end
      step();
    end
  endtask

  task automatic test_scan_async_reset();
    new_run(1);
    while (cyc < run_act + 7) step();
    for (int k = 0; k < 8; k++) begin
      n_tests += 3;
      if (segsel !== exp_segsel(cyc)) begin n_fail++; $display("FAIL scan_segsel cyc=%0d got %b exp %b", cyc, segsel, exp_segsel(cyc)); end
      if (seg !== exp_seg(cyc))       begin n_fail++; $display("FAIL scan_seg cyc=%0d got %h exp %h", cyc, seg, exp_seg(cyc)); end
      if (busy !== 1'b1)              begin n_fail++; $display("FAIL scan_busy got %b exp 1", busy); end
      step();
    end
    #2;
    reset = 1'b0;
    #1;
    n_tests += 5;
    if (segsel !== 3'b001) begin n_fail++; $display("FAIL areset_segsel got %b exp 001", segsel); end
    if (seg !== 8'h3F)     begin n_fail++; $display("FAIL areset_seg got %h exp 3f", seg); end
    if (extled !== 8'h00)  begin n_fail++; $display("FAIL areset_extled got %h exp 00", extled); end
    if (busy !== 1'b0)     begin n_fail++; $display("FAIL areset_busy got %b exp 0", busy); end
    if (fever !== 1'b0)    begin n_fail++; $display("FAIL areset_fever got %b exp 0", fever); end
    release_reset();
    for (int k = 0; k < 4; k++) begin
      step();
      n_tests++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy got %b exp 0", busy); end
    end
  endtask

  initial begin
    clear_model();
    test_reset();
    test_spin_wrap();
    test_collision();
    test_loss();
    test_win();
    test_scan_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
